// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the 5-stage MIPS core front end.
// The IF/ID register and its flush FSM both import this package.
package cpu_pkg;

    // Instruction word injected as a bubble: sll $0,$0,0.
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

    // Word address of the reset vector (byte address 0x34).
    localparam logic [29:0] CPU_RESET_PC = 30'h0000_000D;

    // Width of the flush drain counter, which covers FLUSH_CYCLES up to 15.
    localparam int FLUSH_CNT_W = 4;

    // Exception-flush FSM state encoding.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // Action the IF/ID datapath register takes in a given cycle (reset excluded).
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } ifid_action_t;

    // Next sequential word address. It wraps modulo 2^30.
    function automatic logic [29:0] pc_next_word(input logic [29:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/if_flush_fsm.sv
// Exception-flush FSM. After an ExcFlush pulse (exception or eret redirect),
// it keeps fetch squashed for FLUSH_CYCLES further cycles. FlushBusy is
// registered. force_bubble also covers the pulse cycle itself.
module if_flush_fsm
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ExcFlush,
    output logic FlushBusy,
    output logic force_bubble
);

    localparam logic [FLUSH_CNT_W-1:0] RELOAD_VAL = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    flush_state_t            r_state;
    flush_state_t            w_state_nxt;
    logic [FLUSH_CNT_W-1:0]  r_cnt;
    logic [FLUSH_CNT_W-1:0]  w_cnt_nxt;

    // State register and drain counter. A synchronous reset aborts any flush in progress.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register
        // samples values from before the edge, regardless of block ordering.
        if (Reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. ExcFlush always (re)loads the counter. FLUSH exits after the counter reaches 0.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned (which would infer a latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (ExcFlush) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = RELOAD_VAL;
                end
            end
            ST_FLUSH: begin
                if (ExcFlush) begin
                    w_cnt_nxt = RELOAD_VAL;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: busy comes from the register. The bubble request also covers the pulse cycle.
    always_comb begin
        FlushBusy    = (r_state == ST_FLUSH);
        force_bubble = ExcFlush | FlushBusy;
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with bubble, hold and exception-flush control.
// It captures the fetched word address and instruction for decode, with a
// 1-cycle latency. It follows the same stall qualifiers as the PC register.
// Optional feature: define IFID_PERF_CNT_EN to add the StallCnt and BubbleCnt
// saturating performance counters.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [29:0] RESET_PC     = CPU_RESET_PC,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = CPU_NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [29:0] IF_PC,
    input  logic [31:0] IF_Instr,
    input  logic        hazard,
    input  logic        BranchBubble,
    input  logic        cp0Bubble,
    input  logic        ExcFlush,
    output logic [29:0] ID_PC,
    output logic [29:0] ID_PC4,
    output logic [31:0] ID_Instr,
    output logic        ID_Valid,
    output logic        FlushBusy
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] BubbleCnt
`endif
);

    logic          w_force_bubble;
    logic          w_flush_busy;
    ifid_action_t  w_action;

    logic [29:0]   r_id_pc;
    logic [29:0]   r_id_pc4;
    logic [31:0]   r_id_instr;
    logic          r_id_valid;

    if_flush_fsm #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_fsm (
        .Clk          (Clk),
        .Reset        (Reset),
        .ExcFlush     (ExcFlush),
        .FlushBusy    (w_flush_busy),
        .force_bubble (w_force_bubble)
    );

    // Action priority: a flush bubble beats hazard. Hazard beats a branch or CP0 bubble, so a held instruction is never lost.
    always_comb begin
        w_action = ACT_LOAD;
        if (w_force_bubble) begin
            w_action = ACT_BUBBLE;
        end else if (hazard) begin
            w_action = ACT_HOLD;
        end else if (BranchBubble || cp0Bubble) begin
            w_action = ACT_BUBBLE;
        end
    end

    // Datapath register: reset to the reset vector, then load, hold or inject a bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_id_pc    <= RESET_PC;
            r_id_pc4   <= pc_next_word(RESET_PC);
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else begin
            case (w_action)
                ACT_LOAD: begin
                    r_id_pc    <= IF_PC;
                    r_id_pc4   <= pc_next_word(IF_PC);
                    r_id_instr <= IF_Instr;
                    r_id_valid <= 1'b1;
                end
                ACT_BUBBLE: begin
                    r_id_pc    <= IF_PC;
                    r_id_pc4   <= pc_next_word(IF_PC);
                    r_id_instr <= NOP_INSTR;
                    r_id_valid <= 1'b0;
                end
                default: begin
                    r_id_pc    <= r_id_pc;
                    r_id_pc4   <= r_id_pc4;
                    r_id_instr <= r_id_instr;
                    r_id_valid <= r_id_valid;
                end
            endcase
        end
    end

    assign ID_PC     = r_id_pc;
    assign ID_PC4    = r_id_pc4;
    assign ID_Instr  = r_id_instr;
    assign ID_Valid  = r_id_valid;
    assign FlushBusy = w_flush_busy;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating counts of hold cycles and bubble cycles. Reset cycles are not counted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_action == ACT_HOLD && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_action == ACT_BUBBLE && r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign StallCnt  = r_stall_cnt;
    assign BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed testbench for if_id_reg with default parameters
// (RESET_PC=30'hD, FLUSH_CYCLES=2, NOP_INSTR=0). Inputs are driven on the
// falling edge and outputs are sampled on the next falling edge.
module tb_if_id_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [29:0] IF_PC;
    logic [31:0] IF_Instr;
    logic        hazard;
    logic        BranchBubble;
    logic        cp0Bubble;
    logic        ExcFlush;
    logic [29:0] ID_PC;
    logic [29:0] ID_PC4;
    logic [31:0] ID_Instr;
    logic        ID_Valid;
    logic        FlushBusy;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] StallCnt;
    logic [31:0] BubbleCnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [93:0] got;
    logic [93:0] exp_v;

    if_id_reg dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .IF_PC        (IF_PC),
        .IF_Instr     (IF_Instr),
        .hazard       (hazard),
        .BranchBubble (BranchBubble),
        .cp0Bubble    (cp0Bubble),
        .ExcFlush     (ExcFlush),
        .ID_PC        (ID_PC),
        .ID_PC4       (ID_PC4),
        .ID_Instr     (ID_Instr),
        .ID_Valid     (ID_Valid),
        .FlushBusy    (FlushBusy)
`ifdef IFID_PERF_CNT_EN
        ,
        .StallCnt     (StallCnt),
        .BubbleCnt    (BubbleCnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Set all control and fetch inputs at once.
    task automatic drive(input logic rst, input logic [29:0] pc, input logic [31:0] instr,
                         input logic hz, input logic bb, input logic cb, input logic ef);
        Reset        = rst;
        IF_PC        = pc;
        IF_Instr     = instr;
        hazard       = hz;
        BranchBubble = bb;
        cp0Bubble    = cb;
        ExcFlush     = ef;
    endtask

    // Pack the expected output set {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy}.
    function automatic logic [93:0] pack(input logic [29:0] pc, input logic [29:0] pc4,
                                         input logic [31:0] instr, input logic v, input logic busy);
        return {pc, pc4, instr, v, busy};
    endfunction

    task automatic test_reset();
        drive(1'b1, 30'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'hD, 30'hE, 32'h0, 1'b0, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_load();
        drive(1'b0, 30'hD, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'hD, 30'hE, 32'h2008_0005, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL first_load got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_hazard();
        drive(1'b0, 30'h10, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h10, 30'h11, 32'hAAAA_0001, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL hazard_preload got=%h want=%h", got, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 30'h11 + 30'(i), 32'hF000_0000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL hazard_hold_%0d got=%h want=%h", i, got, exp_v);
            end
        end
        drive(1'b0, 30'h14, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h14, 30'h15, 32'hBBBB_0002, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL hazard_resume got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_branch_bubble();
        drive(1'b0, 30'h15, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h15, 30'h16, 32'h0, 1'b0, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL branch_bubble got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h16, 32'hDDDD_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 30'h17, 32'hEEEE_0005, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h16, 30'h17, 32'hDDDD_0004, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL hazard_beats_branch got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h18, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h18, 30'h19, 32'h0, 1'b0, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL cp0_bubble got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_exc_flush();
        drive(1'b0, 30'h20, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // ExcFlush pulse with hazard high throughout: three bubble edges, then hold.
        drive(1'b0, 30'h30, 32'h9999_0001, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h30, 30'h31, 32'h0, 1'b0, 1'b1);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL flush_edge0 got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h31, 32'h9999_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h31, 30'h32, 32'h0, 1'b0, 1'b1);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL flush_edge1 got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h32, 32'h9999_0003, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h32, 30'h33, 32'h0, 1'b0, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL flush_edge2 got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h33, 32'h9999_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL flush_then_hold got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_reflush();
        logic [29:0] pcs[5];
        logic        busy[5];
        pcs  = '{30'h40, 30'h41, 30'h42, 30'h43, 30'h44};
        busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        // ExcFlush on cycle 0 and again on cycle 2 (the second FLUSH cycle).
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, pcs[i], 32'h7777_7777, 1'b0, 1'b0, 1'b0, (i == 0 || i == 2));
            tick();
            got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
            exp_v = pack(pcs[i], pcs[i] + 30'd1, 32'h0, 1'b0, busy[i]);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reflush_cyc%0d got=%h want=%h", i, got, exp_v);
            end
        end
        drive(1'b0, 30'h45, 32'h5555_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h45, 30'h46, 32'h5555_0005, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reflush_resume got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b0, 30'h50, 32'h8888_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 30'h51, 32'h8888_0002, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'hD, 30'hE, 32'h0, 1'b0, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_flush got=%h want=%h", got, exp_v);
        end
        drive(1'b0, 30'h60, 32'h6666_0006, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h60, 30'h61, 32'h6666_0006, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL flush_aborted got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 30'h3FFF_FFFF, 32'h7777_0007, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        got = {ID_PC, ID_PC4, ID_Instr, ID_Valid, FlushBusy};
        exp_v = pack(30'h3FFF_FFFF, 30'h0, 32'h7777_0007, 1'b1, 1'b0);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL pc4_wrap got=%h want=%h", got, exp_v);
        end
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_perf();
        drive(1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({StallCnt, BubbleCnt} !== 64'h0) begin
            errors++;
            $display("FAIL perf_reset got=%h/%h want=0/0", StallCnt, BubbleCnt);
        end
        drive(1'b0, 30'h70, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 30'h71, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 30'h72, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 30'h73, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 30'h74, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (StallCnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_stall got=%0d want=3", StallCnt);
        end
        checks++;
        if (BubbleCnt !== 32'd4) begin
            errors++;
            $display("FAIL perf_bubble got=%0d want=4", BubbleCnt);
        end
    endtask
`endif

    initial begin
        drive(1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        test_reset();
        test_load();
        test_hazard();
        test_branch_bubble();
        test_exc_flush();
        test_reflush();
        test_reset_mid_flush();
        test_wrap();
`ifdef IFID_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
